// File: rtl/fifo_fwd_deep_if.sv
// Stream bus of the fall-through FIFO: producer-side write handshake,
// consumer-side read handshake and the occupancy/status outputs.
interface fifo_fwd_deep_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 1
);
  logic                  if_full_n;
  logic                  if_almost_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   if_count;

  // Producer/consumer side of the stream.
  modport master (
    input  if_full_n, if_almost_full_n, if_empty_n, if_dout, if_count,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  // FIFO side of the stream.
  modport slave (
    output if_full_n, if_almost_full_n, if_empty_n, if_dout, if_count,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/fifo_fwd_deep.sv
// First-word fall-through FIFO of DEPTH entries with a zero-latency bypass:
// a word written into an empty FIFO is visible on if_dout in the same cycle
// and, if read in that cycle, passes straight through without being stored.
module fifo_fwd_deep #(
  parameter string MEM_STYLE  = "",
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 1,
  parameter int    DEPTH      = 2,
  parameter int    AF_MARGIN  = 1
) (
  input  logic           clk,
  input  logic           reset,
  fifo_fwd_deep_if.slave bus
);
  localparam int CW       = ADDR_WIDTH + 1;
  localparam int AF_LIMIT = DEPTH - AF_MARGIN;
  localparam logic [CW-1:0]         COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         COUNT_AF   = CW'(AF_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [CW-1:0]         count_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [DATA_WIDTH-1:0] head_data;

  logic wr, rd, push, pop, bypass, mem_we, rd_adv, count_zero;

  assign wr         = bus.if_write & bus.if_write_ce;
  assign rd         = bus.if_read  & bus.if_read_ce;
  assign count_zero = (count_reg == '0);

  // Flags come from registered occupancy only; reset forces them low so the
  // producer and consumer both see a stalled FIFO while reset is held.
  assign bus.if_full_n        = ~reset & (count_reg != COUNT_FULL);
  assign bus.if_almost_full_n = ~reset & (count_reg < COUNT_AF);
  assign bus.if_empty_n       = ~reset & (~count_zero | wr);
  assign bus.if_count         = count_reg;
  assign bus.if_dout          = count_zero ? bus.if_din : head_data;

  // A pop on an empty FIFO is only possible with a simultaneous write, which
  // is the pass-through case: the word never touches storage.
  assign push   = wr & bus.if_full_n;
  assign pop    = rd & bus.if_empty_n;
  assign bypass = count_zero & push & pop;
  assign mem_we = push & ~bypass;
  assign rd_adv = pop  & ~bypass;

  // Storage is never reset; only pointers and count carry reset state.
  generate
    if (MEM_STYLE == "") begin : g_mem_plain
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      // Store each accepted, non-bypassed word at the write pointer.
      always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_reg] <= bus.if_din;
      end
      assign head_data = mem[rd_ptr_reg];
    end else begin : g_mem_attr
      (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      // Store each accepted, non-bypassed word at the write pointer.
      always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_reg] <= bus.if_din;
      end
      assign head_data = mem[rd_ptr_reg];
    end
  endgenerate

  // Advance pointers with an explicit wrap at DEPTH-1 (DEPTH need not be a
  // power of two) and track occupancy as pushes minus pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (mem_we) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
      if (rd_adv) rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
      count_reg <= count_reg + CW'(mem_we) - CW'(rd_adv);
    end
  end
endmodule
